rollover_scheduler: RTL and testbench

Programmable multi-channel rollover generator that sequences the divided-clock toggle stages of the design. From one system clock it produces per-channel single-cycle rollover pulses at software-set divisors, plus a common clock-reset pulse so every downstream toggle stage starts phase-aligned. It sits between the configuration/control logic and the bank of rollover-driven clock stages.

---
 rtl/rollover_sched_pkg.sv | 19 +
 rtl/rollover_channel.sv | 111 +++++++++++
 rtl/rollover_scheduler.sv | 86 ++++++++
 tb/tb_rollover_scheduler.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rollover_sched_pkg.sv
// Shared types and defaults for the rollover scheduler.
// Optional live divisor update is enabled by defining ROLLOVER_SCHED_LIVE_CFG_EN.
package rollover_sched_pkg;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_CNT_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_RUN  = 2'd2
    } sched_state_e;

    // Channel-select width; a single-channel build still needs one select bit.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rollover_channel.sv
// One rollover channel: divisor register, down-counter and registered pulse.
// With ROLLOVER_SCHED_LIVE_CFG_EN a shadow divisor allows updates while running.
module rollover_channel
    import rollover_sched_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             run,
    input  logic             go,
    input  logic             wr,
`ifdef ROLLOVER_SCHED_LIVE_CFG_EN
    input  logic             live,
`endif
    input  logic [CNT_W-1:0] wr_div,
    output logic             pulse
);

    logic [CNT_W-1:0] div_reg, div_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             pulse_next;

    function automatic logic [CNT_W-1:0] reload(input logic [CNT_W-1:0] d);
        return (d == '0) ? '0 : d - 1'b1;
    endfunction

`ifdef ROLLOVER_SCHED_LIVE_CFG_EN
    logic [CNT_W-1:0] shadow_reg, shadow_next;
    logic             pending_reg, pending_next;

    always_comb begin
        div_next     = div_reg;
        cnt_next     = cnt_reg;
        shadow_next  = shadow_reg;
        pending_next = pending_reg;
        if (load) begin
            if (pending_reg) begin
                div_next     = shadow_reg;
                pending_next = 1'b0;
            end
            cnt_next = reload(div_next);
        end else if (run && div_reg != '0) begin
            if (cnt_reg == '0) begin
                // Old period has completed: a pending divisor takes over here.
                if (pending_reg) begin
                    div_next     = shadow_reg;
                    pending_next = 1'b0;
                end
                cnt_next = reload(div_next);
            end else begin
                cnt_next = cnt_reg - 1'b1;
            end
        end
        if (wr) begin
            if (!live) begin
                div_next     = wr_div;
                pending_next = 1'b0;
            end else if (div_next != '0) begin
                shadow_next  = wr_div;
                pending_next = 1'b1;
            end else begin
                // A disabled channel has no period to finish, so it starts at once.
                div_next = wr_div;
                cnt_next = reload(wr_div);
            end
        end
        pulse_next = go && (div_next != '0) && (cnt_next == '0);
    end
`else
    always_comb begin
        div_next = div_reg;
        cnt_next = cnt_reg;
        if (load) begin
            cnt_next = reload(div_reg);
        end else if (run && div_reg != '0) begin
            cnt_next = (cnt_reg == '0) ? reload(div_reg) : cnt_reg - 1'b1;
        end
        if (wr) begin
            div_next = wr_div;
        end
        pulse_next = go && (div_next != '0) && (cnt_next == '0);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_reg <= '0;
            cnt_reg <= '0;
            pulse   <= 1'b0;
        end else begin
            div_reg <= div_next;
            cnt_reg <= cnt_next;
            pulse   <= pulse_next;
        end
    end

`ifdef ROLLOVER_SCHED_LIVE_CFG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_reg  <= '0;
            pending_reg <= 1'b0;
        end else begin
            shadow_reg  <= shadow_next;
            pending_reg <= pending_next;
        end
    end
`endif

endmodule

// File: rtl/rollover_scheduler.sv
// Multi-channel rollover generator with a common phase-aligning clock-reset pulse.
// Define ROLLOVER_SCHED_LIVE_CFG_EN to accept divisor writes while running.
module rollover_scheduler
    import rollover_sched_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic                          i_cfg_valid,
    output logic                          o_cfg_ready,
    input  logic [ch_width(NUM_CH)-1:0]   i_cfg_ch,
    input  logic [CNT_W-1:0]              i_cfg_div,
    input  logic                          i_start,
    input  logic                          i_stop,
    output logic [NUM_CH-1:0]             o_roll_over,
    output logic                          o_clk_reset,
    output logic                          o_running
);

    localparam int CH_W = ch_width(NUM_CH);

    sched_state_e state_reg, state_next;
    logic         clk_reset_reg, running_reg;
    logic         load, run, go, cfg_fire;

    // Stop has priority over start in every state.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (i_start && !i_stop) state_next = ST_SYNC;
            ST_SYNC: state_next = i_stop ? ST_IDLE : ST_RUN;
            ST_RUN:  if (i_stop) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    assign load = (state_reg == ST_SYNC);
    assign run  = (state_reg == ST_RUN) && !i_stop;
    assign go   = (state_next == ST_RUN);

`ifdef ROLLOVER_SCHED_LIVE_CFG_EN
    assign o_cfg_ready = (state_reg == ST_IDLE) || (state_reg == ST_RUN);
`else
    assign o_cfg_ready = (state_reg == ST_IDLE);
`endif
    assign cfg_fire = i_cfg_valid && o_cfg_ready;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_reg     <= ST_IDLE;
            clk_reset_reg <= 1'b0;
            running_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            clk_reset_reg <= (state_next == ST_SYNC);
            running_reg   <= (state_next == ST_RUN);
        end
    end

    assign o_clk_reset = clk_reset_reg;
    assign o_running   = running_reg;

    // Out-of-range channel selects match no channel and are silently dropped.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            rollover_channel #(
                .CNT_W (CNT_W)
            ) u_ch (
                .clk    (i_clk),
                .rst_n  (i_reset_n),
                .load   (load),
                .run    (run),
                .go     (go),
                .wr     (cfg_fire && (i_cfg_ch == CH_W'(gi))),
`ifdef ROLLOVER_SCHED_LIVE_CFG_EN
                .live   (state_reg == ST_RUN),
`endif
                .wr_div (i_cfg_div),
                .pulse  (o_roll_over[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_rollover_scheduler.sv
// Bench for rollover_scheduler: directed scenarios plus random runs against a
// pulse-schedule model (absolute cycle of each channel's next pulse).
module tb_rollover_scheduler;

    localparam int NUM_CH = 3;
    localparam int CNT_W  = 16;
    localparam int CH_W   = 2;
`ifdef ROLLOVER_SCHED_LIVE_CFG_EN
    localparam bit LIVE = 1'b1;
`else
    localparam bit LIVE = 1'b0;
`endif

    logic              i_clk = 1'b0;
    logic              i_reset_n = 1'b1;
    logic              i_cfg_valid = 1'b0;
    logic              o_cfg_ready;
    logic [CH_W-1:0]   i_cfg_ch = '0;
    logic [CNT_W-1:0]  i_cfg_div = '0;
    logic              i_start = 1'b0;
    logic              i_stop = 1'b0;
    logic [NUM_CH-1:0] o_roll_over;
    logic              o_clk_reset;
    logic              o_running;

    always #5 i_clk = ~i_clk;

    rollover_scheduler #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W)
    ) dut (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_cfg_valid (i_cfg_valid),
        .o_cfg_ready (o_cfg_ready),
        .i_cfg_ch    (i_cfg_ch),
        .i_cfg_div   (i_cfg_div),
        .i_start     (i_start),
        .i_stop      (i_stop),
        .o_roll_over (o_roll_over),
        .o_clk_reset (o_clk_reset),
        .o_running   (o_running)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: 0 idle, 1 sync, 2 run; cyc numbers the clock period after each edge.
    int cyc = 0;
    int m_state = 0;
    int m_div[NUM_CH];
    int m_next[NUM_CH];
    int m_shadow[NUM_CH];
    bit m_pend[NUM_CH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit m_ready();
        return (m_state == 0) || (LIVE && m_state == 2);
    endfunction

    task automatic model_reset();
        m_state = 0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            m_div[ch] = 0; m_next[ch] = 0; m_shadow[ch] = 0; m_pend[ch] = 1'b0;
        end
    endtask

    task automatic model_edge();
        int  old;
        int  ch;
        bit  acc;
        old = cyc;
        cyc++;
        if (!i_reset_n) begin
            model_reset();
            return;
        end
        // Channels that pulsed in the cycle just ended schedule their next pulse.
        if (m_state == 2) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (m_div[c] != 0 && m_next[c] == old) begin
                    if (m_pend[c]) begin
                        m_div[c] = m_shadow[c];
                        m_pend[c] = 1'b0;
                    end
                    m_next[c] = old + m_div[c];
                end
            end
        end
        if (i_cfg_valid) begin
            ch  = int'(i_cfg_ch);
            acc = m_ready();
            $display("cfg  cycle=%0d ch=%0d div=%0d %s", old, ch, i_cfg_div,
                     !acc ? "not-ready" : (ch >= NUM_CH) ? "discarded" : "accepted");
            if (acc && ch < NUM_CH) begin
                if (m_state == 2) begin
                    if (m_div[ch] == 0) begin
                        m_div[ch]  = int'(i_cfg_div);
                        m_next[ch] = cyc + m_div[ch] - 1;
                    end else begin
                        m_shadow[ch] = int'(i_cfg_div);
                        m_pend[ch]   = 1'b1;
                    end
                end else begin
                    m_div[ch]  = int'(i_cfg_div);
                    m_pend[ch] = 1'b0;
                end
            end
        end
        case (m_state)
            0: if (i_start && !i_stop) m_state = 1;
            1: begin
                if (i_stop) m_state = 0;
                else begin
                    m_state = 2;
                    for (int c = 0; c < NUM_CH; c++) begin
                        if (m_pend[c]) begin
                            m_div[c] = m_shadow[c];
                            m_pend[c] = 1'b0;
                        end
                        m_next[c] = cyc - 1 + m_div[c];
                    end
                end
            end
            default: if (i_stop) m_state = 0;
        endcase
    endtask

    task automatic compare();
        logic [NUM_CH-1:0] e;
        for (int c = 0; c < NUM_CH; c++)
            e[c] = (m_state == 2) && (m_div[c] != 0) && (m_next[c] == cyc);
        check("roll_over", 32'(o_roll_over), 32'(e));
        check("clk_reset", 32'(o_clk_reset), 32'(m_state == 1));
        check("running",   32'(o_running),   32'(m_state == 2));
        check("cfg_ready", 32'(o_cfg_ready), 32'(m_ready()));
    endtask

    task automatic tick();
        @(posedge i_clk);
        model_edge();
        @(negedge i_clk);
        compare();
    endtask

    task automatic cfg_write(input int ch, input int d);
        i_cfg_valid = 1'b1;
        i_cfg_ch    = ch[CH_W-1:0];
        i_cfg_div   = d[CNT_W-1:0];
        tick();
        i_cfg_valid = 1'b0;
    endtask

    task automatic start_run(input int n);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (n) tick();
    endtask

    task automatic stop_run();
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
        tick();
    endtask

    initial begin
        int len;
        model_reset();
        #1 i_reset_n = 1'b0;
        repeat (2) tick();
        i_reset_n = 1'b1;
        tick();

        // ch0=3, ch1=1, ch2 disabled; run long enough to see ch2 stay quiet
        cfg_write(0, 3);
        cfg_write(1, 1);
        cfg_write(2, 0);
        start_run(50);
        stop_run();

        // start and stop together: in IDLE, then in RUN
        i_start = 1'b1; i_stop = 1'b1;
        tick();
        i_start = 1'b0; i_stop = 1'b0;
        repeat (3) tick();
        start_run(6);
        i_start = 1'b1; i_stop = 1'b1;
        tick();
        i_start = 1'b0; i_stop = 1'b0;
        repeat (3) tick();

        // divisor change while running: 5 -> 2 on ch0, written between pulses
        cfg_write(0, 5);
        cfg_write(1, 4);
        start_run(6);
        cfg_write(0, 2);
        repeat (20) tick();
        stop_run();

        // out-of-range channel select is accepted and dropped
        cfg_write(NUM_CH, 1);
        start_run(12);
        stop_run();

        // asynchronous reset mid-run, then a restart with cleared divisors
        cfg_write(0, 3);
        cfg_write(1, 1);
        start_run(5);
        #2 i_reset_n = 1'b0;
        #1;
        check("rst_roll_over", 32'(o_roll_over), 32'd0);
        check("rst_clk_reset", 32'(o_clk_reset), 32'd0);
        check("rst_running",   32'(o_running),   32'd0);
        check("rst_cfg_ready", 32'(o_cfg_ready), 32'd1);
        model_reset();
        repeat (2) tick();
        i_reset_n = 1'b1;
        tick();
        start_run(15);
        stop_run();

        // random configuration, start/stop and mid-run writes
        for (int r = 0; r < 10; r++) begin
            repeat (3) cfg_write($urandom_range(0, 3), $urandom_range(0, 6));
            i_start = 1'b1;
            i_stop  = ($urandom_range(0, 7) == 0);
            tick();
            i_start = 1'b0;
            i_stop  = 1'b0;
            len = $urandom_range(10, 30);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 5) == 0) cfg_write($urandom_range(0, 3), $urandom_range(0, 6));
                else tick();
            end
            stop_run();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
